// File: rtl/multi_dac_output_pkg.sv
// Shared constants and types for the four-channel I2S DAC output path.
// Words are 32-bit FIFO entries; only the top 24 bits reach the DAC pins.
package multi_dac_output_pkg;

  localparam int dac_channels  = 4;
  localparam int dac_word_w    = 32;
  localparam int dac_data_w    = 24;
  localparam int bck_div       = 4;
  localparam int bits_per_half = 32;

  localparam int buf_w = dac_channels * dac_word_w;
  localparam int sr_w  = 2 * dac_data_w;
  localparam int ch_w  = $clog2(dac_channels);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE
  } fill_state_t;

  function automatic logic [dac_data_w-1:0] dac_sample(input logic [dac_word_w-1:0] word);
    return word[dac_word_w-1 -: dac_data_w];
  endfunction

endpackage

// File: rtl/dac_i2s_serializer.sv
// I2S serializer for two stereo DACs: divides capture_clk down to BCK/LRCK and
// shifts one 48-bit register per chip (left sample then right sample).
module dac_i2s_serializer
  import multi_dac_output_pkg::*;
(
  input  logic             capture_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [buf_w-1:0] sample_buf,
  output logic             frame_start,
  output logic             bck,
  output logic             lrck,
  output logic [1:0]       data
);

  localparam int div_w  = (bck_div > 1) ? $clog2(bck_div) : 1;
  localparam int slot_w = $clog2(bits_per_half);

  logic [div_w-1:0]       div_cnt_reg;
  logic [slot_w-1:0]      slot_reg;
  logic                   half_low_reg;
  logic                   active_reg;
  logic                   frame_start_reg;
  logic                   bck_reg;
  logic                   lrck_reg;
  logic [1:0]             data_reg;
  logic [1:0][sr_w-1:0]   sr_reg;
  logic [1:0][sr_w-1:0]   sr_load;
  logic [dac_channels-1:0] pad_unused;

  logic              rise_div;
  logic              last_div;
  logic              last_slot;
  logic [slot_w-1:0] slot_next;
  logic              data_slot_next;

  // DAC0 carries ch0/ch1, DAC1 carries ch2/ch3; left (LRCK high) sample on top.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dac
    assign sr_load[gi] = {dac_sample(sample_buf[(2*gi)*dac_word_w +: dac_word_w]),
                          dac_sample(sample_buf[(2*gi+1)*dac_word_w +: dac_word_w])};
  end

  for (genvar gi = 0; gi < dac_channels; gi++) begin : g_pad
    assign pad_unused[gi] = ^sample_buf[gi*dac_word_w +: (dac_word_w - dac_data_w)];
  end

  assign rise_div       = (div_cnt_reg == div_w'(bck_div/2 - 1));
  assign last_div       = (div_cnt_reg == div_w'(bck_div - 1));
  assign last_slot      = (slot_reg == slot_w'(bits_per_half - 1));
  assign slot_next      = last_slot ? '0 : slot_reg + 1'b1;
  assign data_slot_next = (slot_next >= slot_w'(1)) && (slot_next <= slot_w'(dac_data_w));

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      slot_reg        <= '0;
      half_low_reg    <= 1'b0;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      bck_reg         <= 1'b0;
      lrck_reg        <= 1'b1;
      data_reg        <= '0;
      sr_reg          <= '0;
    end else if (!enable) begin
      div_cnt_reg     <= '0;
      slot_reg        <= '0;
      half_low_reg    <= 1'b0;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      bck_reg         <= 1'b0;
      lrck_reg        <= 1'b1;
      data_reg        <= '0;
    end else if (!active_reg) begin
      // First frame after enable: load immediately and start in slot 0 of the left half.
      active_reg      <= 1'b1;
      div_cnt_reg     <= '0;
      slot_reg        <= '0;
      half_low_reg    <= 1'b0;
      sr_reg          <= sr_load;
      frame_start_reg <= 1'b1;
      bck_reg         <= 1'b0;
      lrck_reg        <= 1'b1;
      data_reg        <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      div_cnt_reg     <= last_div ? '0 : div_cnt_reg + 1'b1;
      if (rise_div) begin
        bck_reg <= 1'b1;
      end
      if (last_div) begin
        // BCK falling edge: everything the DAC samples changes here.
        bck_reg  <= 1'b0;
        slot_reg <= slot_next;
        data_reg <= '0;
        if (last_slot) begin
          half_low_reg <= !half_low_reg;
          lrck_reg     <= half_low_reg;
          if (half_low_reg) begin
            sr_reg          <= sr_load;
            frame_start_reg <= 1'b1;
          end
        end else if (data_slot_next) begin
          for (int i = 0; i < 2; i++) begin
            data_reg[i] <= sr_reg[i][sr_w-1];
            sr_reg[i]   <= {sr_reg[i][sr_w-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign frame_start = frame_start_reg;
  assign bck         = bck_reg;
  assign lrck        = lrck_reg;
  assign data        = data_reg;

endmodule

// File: rtl/multi_dac_output.sv
// DAC output top: synchronizes the host open flag, refills a four-word sample
// buffer from the FIFO once per frame and drives the I2S serializer.
module multi_dac_output
  import multi_dac_output_pkg::*;
(
  input  logic                  capture_clk,
  input  logic                  rst_n,
  input  logic                  dac_fifo_open_bus,
  input  logic [dac_word_w-1:0] dac_fifo_data,
  input  logic                  dac_empty,
  output logic                  dac_rden,
  output logic                  dac_open,
  output logic                  dac_underrun,
  output logic                  DAC_BCK,
  output logic [1:0]            DAC_DATA_PINS,
  output logic                  DAC_LRCK,
  output logic                  DAC_NOT_RST
);

  logic              open_meta_reg;
  logic              open_sync_reg;
  logic              not_rst_reg;
  fill_state_t       fill_state_reg;
  logic [ch_w-1:0]   rd_ch_reg;
  logic [ch_w-1:0]   cap_ch_reg;
  logic              rden_reg;
  logic              cap_pending_reg;
  logic              underrun_reg;
  logic [buf_w-1:0]  word_buf;
  logic              frame_start;

  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      open_meta_reg <= 1'b0;
      open_sync_reg <= 1'b0;
      not_rst_reg   <= 1'b0;
    end else begin
      open_meta_reg <= dac_fifo_open_bus;
      open_sync_reg <= open_meta_reg;
      not_rst_reg   <= open_sync_reg;
    end
  end

  // Each read takes READ+CAPTURE so dac_empty is always sampled after the previous pop.
  always_ff @(posedge capture_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_reg  <= IDLE;
      rd_ch_reg       <= '0;
      cap_ch_reg      <= '0;
      rden_reg        <= 1'b0;
      cap_pending_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      rden_reg        <= 1'b0;
      underrun_reg    <= 1'b0;
      cap_pending_reg <= rden_reg;
      cap_ch_reg      <= rd_ch_reg;
      if (!open_sync_reg) begin
        fill_state_reg  <= IDLE;
        rd_ch_reg       <= '0;
        cap_pending_reg <= 1'b0;
      end else begin
        case (fill_state_reg)
          IDLE: begin
            if (frame_start) begin
              rd_ch_reg      <= '0;
              fill_state_reg <= READ;
            end
          end
          READ: begin
            if (dac_empty) begin
              underrun_reg   <= 1'b1;
              fill_state_reg <= IDLE;
            end else begin
              rden_reg       <= 1'b1;
              fill_state_reg <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (rd_ch_reg == ch_w'(dac_channels - 1)) begin
              fill_state_reg <= IDLE;
            end else begin
              rd_ch_reg      <= rd_ch_reg + 1'b1;
              fill_state_reg <= READ;
            end
          end
          default: fill_state_reg <= IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < dac_channels; gi++) begin : g_word
    logic [dac_word_w-1:0] word_reg;
    always_ff @(posedge capture_clk or negedge rst_n) begin
      if (!rst_n) begin
        word_reg <= '0;
      end else if (cap_pending_reg && (cap_ch_reg == ch_w'(gi))) begin
        word_reg <= dac_fifo_data;
      end
    end
    assign word_buf[gi*dac_word_w +: dac_word_w] = word_reg;
  end

  dac_i2s_serializer u_serializer (
    .capture_clk (capture_clk),
    .rst_n       (rst_n),
    .enable      (open_sync_reg),
    .sample_buf  (word_buf),
    .frame_start (frame_start),
    .bck         (DAC_BCK),
    .lrck        (DAC_LRCK),
    .data        (DAC_DATA_PINS)
  );

  assign dac_rden     = rden_reg;
  assign dac_open     = open_sync_reg;
  assign dac_underrun = underrun_reg;
  assign DAC_NOT_RST  = not_rst_reg;

endmodule

// File: tb/tb_multi_dac_output.sv
// Randomized bench: a queue-based FIFO feeds the DUT while a pin monitor
// reassembles I2S frames and compares them against a per-frame buffer model.
`timescale 1ns/1ps
module tb_multi_dac_output;

  logic        capture_clk = 1'b0;
  logic        rst_n;
  logic        dac_fifo_open_bus;
  logic [31:0] dac_fifo_data;
  logic        dac_empty;
  logic        dac_rden;
  logic        dac_open;
  logic        dac_underrun;
  logic        DAC_BCK;
  logic [1:0]  DAC_DATA_PINS;
  logic        DAC_LRCK;
  logic        DAC_NOT_RST;

  always #5 capture_clk = ~capture_clk;

  multi_dac_output dut (
    .capture_clk       (capture_clk),
    .rst_n             (rst_n),
    .dac_fifo_open_bus (dac_fifo_open_bus),
    .dac_fifo_data     (dac_fifo_data),
    .dac_empty         (dac_empty),
    .dac_rden          (dac_rden),
    .dac_open          (dac_open),
    .dac_underrun      (dac_underrun),
    .DAC_BCK           (DAC_BCK),
    .DAC_DATA_PINS     (DAC_DATA_PINS),
    .DAC_LRCK          (DAC_LRCK),
    .DAC_NOT_RST       (DAC_NOT_RST)
  );

  // Host FIFO: output register updates on the edge that sees dac_rden.
  logic [31:0] fifo_mem [256];
  logic [7:0]  fifo_wr = 8'd0;
  logic [7:0]  fifo_rd = 8'd0;
  assign dac_empty = (fifo_wr == fifo_rd);

  always @(posedge capture_clk) begin
    if (dac_rden && !dac_empty) begin
      dac_fifo_data <= fifo_mem[fifo_rd];
      fifo_rd       <= fifo_rd + 8'd1;
    end
  end

  // Pin monitor: one record per completed LRCK-high + LRCK-low frame.
  typedef struct packed {
    logic [3:0][31:0] w;
    logic             bad;
  } frame_rec_t;

  frame_rec_t frame_q [$];
  frame_rec_t cur;
  int   cyc_cnt = 0, rden_cnt = 0, unr_cnt = 0, closed_rden_cnt = 0;
  int   lrck_rise_cnt = 0, bck_rise_cnt = 0, bck_high_cnt = 0;
  int   slot = 0;
  logic bck_prev = 1'b0, lrck_prev = 1'b1, collecting = 1'b0, cur_high = 1'b1;

  always @(negedge capture_clk) begin
    cyc_cnt++;
    if (DAC_BCK) bck_high_cnt++;
    if (dac_rden) begin
      rden_cnt++;
      if (!dac_open) closed_rden_cnt++;
    end
    if (dac_underrun) unr_cnt++;
    if (DAC_LRCK && !lrck_prev) lrck_rise_cnt++;
    if (!dac_open) begin
      collecting = 1'b0;
    end else if (DAC_BCK && !bck_prev) begin
      bck_rise_cnt++;
      if (!collecting) begin
        collecting = 1'b1;
        cur        = '0;
        cur.bad    = !DAC_LRCK;
        cur_high   = DAC_LRCK;
        slot       = 0;
      end else if (DAC_LRCK != cur_high) begin
        if (slot != 32) cur.bad = 1'b1;
        if (!cur_high) begin
          frame_q.push_back(cur);
          cur = '0;
        end
        cur_high = DAC_LRCK;
        slot     = 0;
      end
      if (slot >= 1 && slot <= 24) begin
        cur.w[cur_high ? 0 : 1][32 - slot] = DAC_DATA_PINS[0];
        cur.w[cur_high ? 2 : 3][32 - slot] = DAC_DATA_PINS[1];
      end else if (DAC_DATA_PINS != 2'b00) begin
        cur.bad = 1'b1;
      end
      slot++;
    end
    bck_prev  = DAC_BCK;
    lrck_prev = DAC_LRCK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame outputs the buffer as it stood at frame start,
  // then up to four queued words overwrite channels 0..3 in order.
  logic [31:0] model_buf [4] = '{default: 32'h0};
  logic [31:0] model_q   [$];
  logic [31:0] exp_words [4];
  int exp_reads;
  bit exp_unr;
  bit frame_first;
  int snap_rden, snap_unr, snap_cyc, snap_bck, snap_lrck;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge capture_clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[fifo_wr] = w;
    fifo_wr           = fifo_wr + 8'd1;
    model_q.push_back(w);
  endtask

  task automatic take_snapshot();
    snap_rden = rden_cnt;
    snap_unr  = unr_cnt;
    snap_cyc  = cyc_cnt;
    snap_bck  = bck_rise_cnt;
    snap_lrck = lrck_rise_cnt;
  endtask

  task automatic frame_begin(input bit first);
    for (int c = 0; c < 4; c++) exp_words[c] = model_buf[c];
    exp_reads = 0;
    while (exp_reads < 4 && model_q.size() > 0) begin
      model_buf[exp_reads] = model_q.pop_front();
      exp_reads++;
    end
    exp_unr     = (exp_reads < 4);
    frame_first = first;
    if (first) take_snapshot();
  endtask

  task automatic frame_finish(input string tag);
    int t;
    frame_rec_t rec;
    t = 0;
    while (lrck_rise_cnt == snap_lrck && t < 400) begin
      tick(1);
      t++;
    end
    check({tag, "_lrck_rise"}, 64'(lrck_rise_cnt != snap_lrck), 64'(1));
    check({tag, "_rden_count"}, 64'(rden_cnt - snap_rden), 64'(exp_reads));
    check({tag, "_underrun_count"}, 64'(unr_cnt - snap_unr), 64'(exp_unr));
    if (!frame_first) begin
      check({tag, "_lrck_period"}, 64'(cyc_cnt - snap_cyc), 64'(256));
      check({tag, "_bck_per_frame"}, 64'(bck_rise_cnt - snap_bck), 64'(64));
    end
    take_snapshot();
    t = 0;
    while (frame_q.size() == 0 && t < 16) begin
      tick(1);
      t++;
    end
    if (frame_q.size() == 0) begin
      check({tag, "_frame_record"}, 64'(0), 64'(1));
    end else begin
      rec = frame_q.pop_front();
      check({tag, "_frame_format"}, 64'(rec.bad), 64'(0));
      for (int c = 0; c < 4; c++)
        check($sformatf("%s_ch%0d", tag, c), 64'(rec.w[c]), 64'(exp_words[c] & 32'hFFFF_FF00));
    end
    $display("frame %s: reads=%0d underrun=%0d ch0=%h ch1=%h ch2=%h ch3=%h", tag,
             exp_reads, exp_unr, exp_words[0], exp_words[1], exp_words[2], exp_words[3]);
  endtask

  task automatic run_frame(input string tag, input bit first, input int npush);
    frame_begin(first);
    tick(64);
    for (int i = 0; i < npush; i++) push_word($urandom);
    frame_finish(tag);
  endtask

  task automatic wait_open(input string tag);
    int t;
    t = 0;
    while (!dac_open && t < 10) begin
      tick(1);
      t++;
    end
    check({tag, "_open_latency"}, 64'(t), 64'(2));
  endtask

  initial begin
    logic [31:0] dir_words [4];
    int snap;
    dir_words = '{32'h0A1B0C1D, 32'h1A1B1C1D, 32'h2A1B2C1D, 32'h3A1B3C1D};
    rst_n             = 1'b0;
    dac_fifo_open_bus = 1'b0;
    tick(3);
    check("rst_lrck", 64'(DAC_LRCK), 64'(1));
    check("rst_outputs", 64'({DAC_BCK, DAC_DATA_PINS, DAC_NOT_RST, dac_rden, dac_open, dac_underrun}), 64'(0));

    rst_n = 1'b1;
    tick(20);
    check("idle_bck_high", 64'(bck_high_cnt), 64'(0));
    check("idle_rden", 64'(rden_cnt), 64'(0));
    check("idle_lrck", 64'(DAC_LRCK), 64'(1));

    dac_fifo_open_bus = 1'b1;
    wait_open("open");
    frame_begin(1'b1);
    tick(1);
    check("open_not_rst", 64'(DAC_NOT_RST), 64'(1));
    tick(63);
    frame_finish("empty0");

    run_frame("empty1", 1'b0, 0);
    // Directed sample pushed mid-frame: fetched at the next frame start, played one frame later.
    frame_begin(1'b0);
    tick(64);
    for (int i = 0; i < 4; i++) push_word(dir_words[i]);
    frame_finish("fill0");
    run_frame("fill1", 1'b0, 4);
    run_frame("directed", 1'b0, 2);
    run_frame("partial_fetch", 1'b0, 4);
    run_frame("partial_out", 1'b0, 0);

    for (int f = 0; f < 6; f++)
      run_frame($sformatf("rand%0d", f), 1'b0, int'($urandom_range(0, 4)));

    // Close mid-frame with four words waiting in the FIFO.
    frame_begin(1'b0);
    tick(100);
    for (int i = 0; i < 4; i++) push_word($urandom);
    dac_fifo_open_bus = 1'b0;
    tick(3);
    check("close_idle_pins", 64'({DAC_BCK, DAC_DATA_PINS, DAC_NOT_RST, dac_open}), 64'(0));
    check("close_idle_lrck", 64'(DAC_LRCK), 64'(1));
    check("close_rden_count", 64'(rden_cnt - snap_rden), 64'(exp_reads));
    check("close_underrun_count", 64'(unr_cnt - snap_unr), 64'(exp_unr));
    snap = bck_high_cnt + rden_cnt;
    tick(40);
    check("closed_activity", 64'(bck_high_cnt + rden_cnt - snap), 64'(0));
    $display("close: pins idle, reads held");

    dac_fifo_open_bus = 1'b1;
    wait_open("reopen");
    frame_begin(1'b1);
    tick(64);
    frame_finish("reopen0");
    run_frame("reopen1", 1'b0, 0);

    check("rden_while_closed", 64'(closed_rden_cnt), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_dac_output.md
Name: multi_dac_output

Overview:
- Streams 4-channel DAC sample words from a FIFO to two stereo 24-bit I2S DAC chips, DAC0 and DAC1.
- Upper half is a FIFO-reading buffer stage that fetches one 32-bit word per channel per frame.
- Lower half is a serializer that generates BCK, LRCK, two data pins and the DAC reset.
- Sits between the host-written DAC FIFO and the output board pins.

Parameters:
- dac_channels, 4: channels per frame; fixed at 4, 2 per DAC chip.
- bck_div, 4: capture_clk cycles per BCK period; even, >=2.
- bits_per_half, 32: BCK periods per LRCK half-frame; >=26.

Ports:
- capture_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- dac_fifo_open_bus  in  1  host has DAC FIFO open; 2-flop synchronized internally.
- dac_fifo_data  in  32  FIFO output register; valid the cycle after a dac_rden cycle.
- dac_empty  in  1  FIFO empty.
- dac_rden  out  1  FIFO read strobe, one word per high cycle.
- dac_open  out  1  synchronized open; enables the serializer.
- dac_underrun  out  1  one-cycle pulse when a needed word is unavailable.
- DAC_BCK  out  1  bit clock.
- DAC_DATA_PINS  out  2  bit0 = DAC0 serial data, bit1 = DAC1 serial data.
- DAC_LRCK  out  1  word clock.
- DAC_NOT_RST  out  1  DAC reset, active low.

Behaviour:
- Reset:
  - dac_rden, dac_open, dac_underrun, DAC_BCK, DAC_DATA_PINS, DAC_NOT_RST = 0; DAC_LRCK = 1.
  - Internal 128-bit word buffer and request flag = 0.
- Open synchronizer:
  - dac_open follows dac_fifo_open_bus through 2 flops (2-cycle latency).
  - While dac_open=0: no reads; serializer idle with BCK=0, LRCK=1, data=0, DAC_NOT_RST=0; bit/frame counters held at frame start.
  - DAC_NOT_RST = dac_open, registered.
- Serializer:
  - BCK = capture_clk/bck_div, 50% duty, starts low when enabled.
  - LRCK and data change only on BCK falling edges, so the DAC samples on rising edges.
  - Frame = 2 halves of bits_per_half BCK periods each.
  - LRCK high half carries ch0 on DAC0 and ch2 on DAC1.
  - LRCK low half carries ch1 on DAC0 and ch3 on DAC1.
  - In each half, slot 0 (first rising BCK after the LRCK edge) is the I2S delay bit, driven 0.
  - Slots 1..24 carry word bits [31:8], MSB first; the remaining slots are driven 0.
- Frame start (first frame on enable, then each LRCK rising edge):
  - Copy the internal buffer into the output shift registers.
  - Assert an internal request for one cycle.
  - Buffer word n occupies bits [32n+31:32n], n = channel.
- Buffer fill:
  - On request, read channels 0,1,2,3 in order: assert dac_rden for one cycle per word when dac_empty=0.
  - Capture dac_fifo_data the following cycle into word n.
  - Back-to-back reads are allowed. Fill completes in ≤8 cycles, well before the next frame.
- Latency: data for sample k leaves the pins in frame k+1. Frame 0 after enable outputs the prior buffer contents, 0 after reset.
- Underrun:
  - If dac_empty=1 when a word is due, pulse dac_underrun once and abandon the remaining reads for that frame.
  - Unread words keep their previous values. Normal fill resumes at the next request.
- Close mid-operation: an in-progress fill is aborted, the serializer returns to idle, and on reopen it restarts at an LRCK-high half.
- A request arriving while a fill is active is impossible by construction; ignore it.

Decomposition:
- Shared package: dac_channels, DAC word width 32, DAC data width 24, bck_div, bits_per_half.
- One sub-module is natural: dac_i2s_serializer, containing the BCK/LRCK counters and the two shift registers.
- Buffer-fill FSM (states IDLE, READ, CAPTURE) and the synchronizer live in the top.

Test Plan:
- Reset: hold rst_n=0 → LRCK=1, all other outputs 0; release with open_bus=0 → BCK stays 0, no dac_rden.
- Open: raise dac_fifo_open_bus → dac_open=1 two cycles later, DAC_NOT_RST=1, BCK period = 4 cycles, LRCK period = 256 cycles.
- Open with dac_empty=1 → exactly one dac_underrun pulse per frame, dac_rden never high, output words repeat the old buffer (0).
- Streaming: FIFO supplies 0x0A1B0C1D, 0x1A1B1C1D, 0x2A1B2C1D, 0x3A1B3C1D per sample k=1 → in frame k+1, DAC0 serializes 0x0A1B0C (LRCK high) then 0x1A1B1C; DAC1 serializes 0x2A1B2C then 0x3A1B3C. Delay bit = 0. Exactly 4 dac_rden pulses per frame.
- Partial data: dac_empty rises after 2 reads → one underrun pulse; ch2/ch3 repeat the previous sample's values.
- Close/reopen mid-frame: pins idle within 3 cycles of open_bus falling, no further reads; reopen → first half is LRCK high with the stored buffer.
